// File: rtl/ones_window_accumulator_if.sv
// Handshake bundle between the ones counter, the window accumulator and its consumer.
interface ones_window_accumulator_if #(
  parameter int unsigned SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       count_in;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             out_saturated;

  modport slave (
    input  in_valid, count_in, clear, out_ready,
    output in_ready, out_valid, out_sum, out_saturated
  );

  modport master (
    output in_valid, count_in, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_saturated
  );
endinterface

// File: rtl/ones_window_accumulator.sv
// Sums WINDOW consecutive 2-bit ones counts with saturation; one-entry output
// register with valid/ready backpressure and a synchronous partial-window clear.
module ones_window_accumulator #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SUM_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ones_window_accumulator_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

  logic [SUM_W-1:0] acc;
  logic             sat;
  logic [7:0]       idx;
  logic             out_valid_q;
  logic [SUM_W-1:0] out_sum_q;
  logic             out_sat_q;

  logic             last;
  logic             ready_c;
  logic             accept;
  logic             drain;
  logic [SUM_W:0]   sum_ext;
  logic             overflow;
  logic [SUM_W-1:0] sum_sat;

  // The completing sample only stalls while an undrained result would be overwritten.
  always_comb begin
    last     = (idx == LAST_IDX);
    ready_c  = rst_n && !bus.clear && !(last && out_valid_q && !bus.out_ready);
    accept   = bus.in_valid && ready_c;
    drain    = out_valid_q && bus.out_ready;
    sum_ext  = {1'b0, acc} + (SUM_W + 1)'(bus.count_in);
    overflow = sum_ext[SUM_W];
    sum_sat  = overflow ? '1 : sum_ext[SUM_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      sat         <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      if (bus.clear || (accept && last)) begin
        acc <= '0;
        sat <= 1'b0;
        idx <= '0;
      end else if (accept) begin
        acc <= sum_sat;
        sat <= sat | overflow;
        idx <= idx + 8'd1;
      end

      if (accept && last) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= sum_sat;
        out_sat_q   <= sat | overflow;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sum       = out_sum_q;
  assign bus.out_saturated = out_sat_q;

endmodule

// File: tb/tb_ones_window_accumulator.sv
// Directed bench: an 8-bit-sum instance for most scenarios and a 3-bit-sum
// instance for saturation, both WINDOW=8.
module tb_ones_window_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ones_window_accumulator_if #(.SUM_W(8)) ia ();
  ones_window_accumulator_if #(.SUM_W(3)) ib ();

  ones_window_accumulator #(.WINDOW(8), .SUM_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  ones_window_accumulator #(.WINDOW(8), .SUM_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    ia.in_valid = 1'b0; ia.count_in = 2'd0; ia.clear = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.count_in = 2'd0; ib.clear = 1'b0; ib.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", ia.out_sum); end
    checks++; if (ia.out_saturated !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", ia.out_saturated); end
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ia.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ia.in_ready); end
  endtask

  task automatic test_fill();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd3;
      #1;
      checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, ia.in_ready); end
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid[%0d] got=%b exp=0", i, ia.out_valid); end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL fill_out_valid got=%b exp=1", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd24) begin failures++; $display("FAIL fill_out_sum got=%0d exp=24", ia.out_sum); end
    checks++; if (ia.out_saturated !== 1'b0) begin failures++; $display("FAIL fill_out_sat got=%b exp=0", ia.out_saturated); end
    @(negedge clk);
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL fill_pulse_end got=%b exp=0", ia.out_valid); end
  endtask

  task automatic test_mixed();
    logic [1:0] s [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    ia.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = s[i];
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL mixed_out_valid got=%b exp=1", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd12) begin failures++; $display("FAIL mixed_out_sum got=%0d exp=12", ia.out_sum); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd0;
      #1;
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL zeros_early_valid[%0d] got=%b exp=0", i, ia.out_valid); end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL zeros_out_valid got=%b exp=1", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd0) begin failures++; $display("FAIL zeros_out_sum got=%0d exp=0", ia.out_sum); end
    @(negedge clk);
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL zeros_pulse_end got=%b exp=0", ia.out_valid); end
  endtask

  task automatic test_backpressure();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd1;
    end
    // First window (sum 8) completes; hold it while seven samples of 2 are absorbed.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ia.out_ready = 1'b0; ia.in_valid = 1'b1; ia.count_in = 2'd2;
      #1;
      checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL bp_absorb_ready[%0d] got=%b exp=1", i, ia.in_ready); end
      checks++; if (ia.out_valid !== 1'b1 || ia.out_sum !== 8'd8) begin failures++; $display("FAIL bp_hold[%0d] valid=%b sum=%0d exp valid=1 sum=8", i, ia.out_valid, ia.out_sum); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", i, ia.in_ready); end
      checks++; if (ia.out_valid !== 1'b1 || ia.out_sum !== 8'd8) begin failures++; $display("FAIL bp_stall_hold[%0d] valid=%b sum=%0d exp valid=1 sum=8", i, ia.out_valid, ia.out_sum); end
    end
    ia.out_ready = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ia.in_ready); end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b exp=1", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd16) begin failures++; $display("FAIL bp_second_sum got=%0d exp=16", ia.out_sum); end
    @(negedge clk);
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd16) begin failures++; $display("FAIL bp_drain_keep_sum got=%0d exp=16", ia.out_sum); end
  endtask

  task automatic test_clear();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd2;
    end
    @(negedge clk);
    ia.clear = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%b exp=0", ia.in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.clear = 1'b0; ia.in_valid = 1'b1; ia.count_in = 2'd1;
      #1;
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL clear_early_valid[%0d] got=%b exp=0", i, ia.out_valid); end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1 || ia.out_sum !== 8'd8) begin failures++; $display("FAIL clear_result valid=%b sum=%0d exp valid=1 sum=8", ia.out_valid, ia.out_sum); end
    // Clear coinciding with the completing sample restarts the window.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd1;
    end
    @(negedge clk);
    ia.clear = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL clear_last_ready got=%b exp=0", ia.in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.clear = 1'b0; ia.in_valid = 1'b1; ia.count_in = 2'd3;
      #1;
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL clear_last_early_valid[%0d] got=%b exp=0", i, ia.out_valid); end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1 || ia.out_sum !== 8'd24) begin failures++; $display("FAIL clear_last_result valid=%b sum=%0d exp valid=1 sum=24", ia.out_valid, ia.out_sum); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    ib.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ib.in_valid = 1'b1; ib.count_in = 2'd3;
    end
    @(negedge clk);
    ib.in_valid = 1'b0;
    #1;
    checks++; if (ib.out_valid !== 1'b1) begin failures++; $display("FAIL sat_out_valid got=%b exp=1", ib.out_valid); end
    checks++; if (ib.out_sum !== 3'd7) begin failures++; $display("FAIL sat_out_sum got=%0d exp=7", ib.out_sum); end
    checks++; if (ib.out_saturated !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", ib.out_saturated); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ib.in_valid = 1'b1; ib.count_in = 2'd0;
    end
    @(negedge clk);
    ib.in_valid = 1'b0;
    #1;
    checks++; if (ib.out_valid !== 1'b1 || ib.out_sum !== 3'd0) begin failures++; $display("FAIL sat_zero_sum valid=%b sum=%0d exp valid=1 sum=0", ib.out_valid, ib.out_sum); end
    checks++; if (ib.out_saturated !== 1'b0) begin failures++; $display("FAIL sat_zero_flag got=%b exp=0", ib.out_saturated); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    ia.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd2;
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pending got=%b exp=1", ia.out_valid); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", ia.out_valid); end
    checks++; if (ia.out_sum !== 8'd0) begin failures++; $display("FAIL arst_out_sum got=%0d exp=0", ia.out_sum); end
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready got=%b exp=0", ia.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    ia.out_ready = 1'b1;
    #1;
    checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL arst_release_valid got=%b exp=0", ia.out_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.in_valid = 1'b1; ia.count_in = 2'd1;
      #1;
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL arst_early_valid[%0d] got=%b exp=0", i, ia.out_valid); end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 1'b1 || ia.out_sum !== 8'd8) begin failures++; $display("FAIL arst_result valid=%b sum=%0d exp valid=1 sum=8", ia.out_valid, ia.out_sum); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_mixed();
    test_backpressure();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
